// File: rtl/wb_regfile_slave_pkg.sv
// Shared types for the Wishbone register-file slave: FSM state encoding and
// the wait-state counter sizing helper.
package wb_regfile_slave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Counter only ever holds WAIT_STATES-1, so size it for that value.
  function automatic int wait_cnt_width(input int wait_states);
    return (wait_states > 2) ? $clog2(wait_states) : 1;
  endfunction

endpackage

// File: rtl/wb_regfile_slave_if.sv
// Classic Wishbone B4 bus bundle between one master and the register-file slave.
// Signal names keep the slave's point of view (_i driven by master, _o by slave).
interface wb_regfile_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH/8-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;
  logic                    err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_regfile_slave_mem.sv
// DEPTH x DATA_WIDTH register storage with byte-enable write and async clear.
// Out-of-range read addresses return zero.
module wb_regfile_slave_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH/8-1:0] wsel_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int                  NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] words [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic                  hit;
      logic [DATA_WIDTH-1:0] word_q;
      logic [DATA_WIDTH-1:0] word_d;

      assign hit = we_i && (waddr_i == ADDR_WIDTH'(gi));

      always_comb begin
        word_d = word_q;
        for (int b = 0; b < NB; b++) begin
          if (wsel_i[b]) word_d[b*8 +: 8] = wdata_i[b*8 +: 8];
        end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  word_q <= '0;
        else if (hit)  word_q <= word_d;
      end

      assign words[gi] = word_q;
    end
  endgenerate

  assign rdata_o = ({1'b0, raddr_i} < DEPTH_W) ? words[raddr_i] : '0;

endmodule

// File: rtl/wb_regfile_slave.sv
// Classic Wishbone B4 register-file slave with programmable wait states.
// Define WB_REGFILE_SLAVE_ERR_EN to terminate out-of-range accesses with err_o.
module wb_regfile_slave
  import wb_regfile_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_regfile_slave_if.slave wb
);

  localparam int                  CNT_W    = wait_cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;

  logic                    in_range;
  logic                    fault;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  assign in_range = ({1'b0, adr_q} < DEPTH_W);

`ifdef WB_REGFILE_SLAVE_ERR_EN
  assign fault = !in_range;
`else
  assign fault = 1'b0;
`endif

  wb_regfile_slave_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (mem_we),
    .waddr_i (adr_q),
    .wsel_i  (sel_q),
    .wdata_i (wdat_q),
    .raddr_i (adr_q),
    .rdata_o (mem_rdata)
  );

  // ack_o/err_o/dat_o are registered on the edge that leaves RESPOND, so the
  // response lands WAIT_STATES+1 edges after the request was sampled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb.cyc_i && wb.stb_i) begin
          adr_d  = wb.adr_i;
          we_d   = wb.we_i;
          sel_d  = wb.sel_i;
          wdat_d = wb.dat_i;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESPOND;
          end
        end
      end

      WAIT: begin
        if (!wb.cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESPOND: begin
        state_d = IDLE;
        if (fault) begin
          err_d = 1'b1;
        end else begin
          ack_d  = 1'b1;
          mem_we = we_q && in_range;
          if (!we_q) dat_d = in_range ? mem_rdata : '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign wb.dat_o = dat_q;
  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Self-checking bench for wb_regfile_slave: transaction-level model with a
// per-cycle compare process, directed pinning cases and random traffic.
module tb_wb_regfile_slave;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 12;
  localparam int WS    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_cnt = 0;

  wb_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
  wb_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

  wb_regfile_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb(bus)
  );

  wb_regfile_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)
  ) dut_ws0 (
    .clk_i(clk), .rst_n_i(rst_n), .wb(bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Transaction-level model: memory contents plus a schedule of expected
  // responses keyed by the edge number on which they must appear.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_dat;
  int          sched_kind [int];   // 1 = ack, 2 = err
  logic [31:0] sched_dat  [int];   // present only for read responses

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_dat = '0;
    sched_kind.delete();
    sched_dat.delete();
  endtask

  task automatic model_issue(input bit we, input int adr, input logic [3:0] sel,
                             input logic [31:0] dat, input int resp_edge);
    bit hit;
    hit = (adr < DEPTH);
`ifdef WB_REGFILE_SLAVE_ERR_EN
    if (!hit) begin
      sched_kind[resp_edge] = 2;
      return;
    end
`endif
    sched_kind[resp_edge] = 1;
    if (we) begin
      if (hit)
        for (int b = 0; b < 4; b++)
          if (sel[b]) model_mem[adr][b*8 +: 8] = dat[b*8 +: 8];
    end else begin
      sched_dat[resp_edge] = hit ? model_mem[adr] : 32'h0;
    end
  endtask

  always @(negedge clk) begin : cmp
    int k;
    k = sched_kind.exists(cyc_cnt) ? sched_kind[cyc_cnt] : 0;
    if (sched_dat.exists(cyc_cnt)) model_dat = sched_dat[cyc_cnt];
    check("ack_o", {31'b0, bus.ack_o}, {31'b0, k == 1});
    check("err_o", {31'b0, bus.err_o}, {31'b0, k == 2});
    check("ack_err_excl", {31'b0, bus.ack_o & bus.err_o}, 32'h0);
    check("dat_o", bus.dat_o, model_dat);
  end

  // One classic-cycle transfer on the WAIT_STATES=2 slave; abort drops cyc_i
  // in the first WAIT cycle. resp: 0 none, 1 ack, 2 err.
  task automatic xfer(input bit we, input logic [3:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input bit abort,
                      output int lat, output logic [31:0] rdat, output int resp);
    int n;
    lat  = -1;
    resp = 0;
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = adr;  bus.sel_i = sel;  bus.dat_i = dat;
    n = cyc_cnt + 1;
    if (abort) begin
      @(posedge clk); #1;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      repeat (WS + 3) begin
        @(posedge clk); #1;
        if (bus.ack_o || bus.err_o) resp = bus.err_o ? 2 : 1;
      end
    end else begin
      model_issue(we, int'(adr), sel, dat, n + 1 + WS);
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        if (bus.ack_o || bus.err_o) begin
          lat  = cyc_cnt - n;
          resp = bus.err_o ? 2 : 1;
          break;
        end
      end
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      check("xfer_terminated", {31'b0, resp != 0}, 32'h1);
    end
    rdat = bus.dat_o;
    $display("[TB] %s adr=%0d sel=%h dat=%h abort=%0d resp=%0d lat=%0d dat_o=%h",
             we ? "WR" : "RD", adr, sel, dat, abort, resp, lat, rdat);
  endtask

  initial begin
    int          lat, resp, got, n0;
    logic [31:0] rd;
    logic [31:0] vals [4];

    bus.cyc_i  = 0; bus.stb_i  = 0; bus.we_i  = 0; bus.adr_i  = '0; bus.sel_i  = '0; bus.dat_i  = '0;
    bus0.cyc_i = 0; bus0.stb_i = 0; bus0.we_i = 0; bus0.adr_i = '0; bus0.sel_i = '0; bus0.dat_i = '0;
    model_reset();

    #1;
    check("rst_ack",  {31'b0, bus.ack_o}, 32'h0);
    check("rst_err",  {31'b0, bus.err_o}, 32'h0);
    check("rst_dat",  bus.dat_o, 32'h0);
    check("rst_ack0", {31'b0, bus0.ack_o}, 32'h0);
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;

    // Basic write/read latency and data
    xfer(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, lat, rd, resp);
    check("wr3_lat", lat, 32'd3);
    check("wr3_resp", resp, 32'd1);
    xfer(1'b0, 4'd3, 4'hF, 32'h0, 1'b0, lat, rd, resp);
    check("rd3_lat", lat, 32'd3);
    check("rd3_dat", rd, 32'hDEADBEEF);

    // Byte-lane merge
    xfer(1'b1, 4'd5, 4'hF,    32'h11223344, 1'b0, lat, rd, resp);
    xfer(1'b1, 4'd5, 4'b0101, 32'hAABBCCDD, 1'b0, lat, rd, resp);
    xfer(1'b0, 4'd5, 4'h0,    32'h0,        1'b0, lat, rd, resp);
    check("rd5_merge", rd, 32'h11BB33DD);

    // Out-of-range access
    xfer(1'b0, 4'd13, 4'hF, 32'h0, 1'b0, lat, rd, resp);
`ifdef WB_REGFILE_SLAVE_ERR_EN
    check("rd13_resp_err", resp, 32'd2);
    check("rd13_dat_held", rd, 32'h11BB33DD);
`else
    check("rd13_resp_ack", resp, 32'd1);
    check("rd13_dat_zero", rd, 32'h0);
`endif
    check("rd13_lat", lat, 32'd3);
    xfer(1'b1, 4'd13, 4'hF, 32'hFFFFFFFF, 1'b0, lat, rd, resp);
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 4'(i), 4'hF, 32'h0, 1'b0, lat, rd, resp);
      check("oor_wr_no_alias", rd, (i == 3) ? 32'hDEADBEEF : (i == 5) ? 32'h11BB33DD : 32'h0);
    end

    // Abort during WAIT
    xfer(1'b1, 4'd2, 4'hF, 32'h12345678, 1'b1, lat, rd, resp);
    check("abort_no_resp", resp, 32'd0);
    xfer(1'b0, 4'd2, 4'hF, 32'h0, 1'b0, lat, rd, resp);
    check("abort_no_write", rd, 32'h0);

    // Reset in the middle of a transfer
    xfer(1'b1, 4'd7, 4'hF, 32'h00000055, 1'b0, lat, rd, resp);
    xfer(1'b0, 4'd7, 4'hF, 32'h0, 1'b0, lat, rd, resp);
    check("rd7_before_rst", rd, 32'h00000055);
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 4'd7; bus.sel_i = 4'hF; bus.dat_i = 32'h000000AA;
    @(posedge clk); #4;
    rst_n = 1'b0;
    model_reset();
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    #1;
    check("midrst_ack", {31'b0, bus.ack_o}, 32'h0);
    check("midrst_err", {31'b0, bus.err_o}, 32'h0);
    check("midrst_dat", bus.dat_o, 32'h0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    xfer(1'b0, 4'd7, 4'hF, 32'h0, 1'b0, lat, rd, resp);
    check("rd7_after_rst", rd, 32'h0);
    check("first_after_rst_lat", lat, 32'd3);

    // Zero wait states, request held across back-to-back transfers
    for (int i = 0; i < 4; i++) vals[i] = 32'hC0DE0000 + 32'(i * 17 + 1);
    for (int ph = 0; ph < 2; ph++) begin
      @(posedge clk); #1;
      bus0.cyc_i = 1'b1; bus0.stb_i = 1'b1; bus0.we_i = (ph == 0);
      bus0.sel_i = 4'hF; bus0.adr_i = 4'd0; bus0.dat_i = vals[0];
      n0 = cyc_cnt + 1;
      for (int i = 0; i < 4; i++) begin
        got = -1;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          if (bus0.ack_o) begin
            got = cyc_cnt - n0;
            break;
          end
        end
        check("ws0_ack_edge", got, 32'(1 + 2 * i));
        check("ws0_err", {31'b0, bus0.err_o}, 32'h0);
        if (ph == 1) check("ws0_rdat", bus0.dat_o, vals[i]);
        if (i < 3) begin
          bus0.adr_i = 4'(i + 1);
          bus0.dat_i = vals[i + 1];
        end else begin
          bus0.cyc_i = 1'b0; bus0.stb_i = 1'b0;
        end
        $display("[TB] WS0 %s adr=%0d ack_edge=N+%0d dat_o=%h",
                 (ph == 0) ? "WR" : "RD", i, got, bus0.dat_o);
      end
    end

    // Random traffic, checked cycle by cycle against the model
    for (int t = 0; t < 80; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'($urandom_range(0, 1));
      end
      xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom),
           $urandom, ($urandom_range(0, 9) == 0), lat, rd, resp);
    end

    repeat (5) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile_slave.md
WB_REGFILE_SLAVE -- requirements
Module: wb_regfile_slave

Interface
REQ-001 Parameter: ADDR_WIDTH, 4, word-address width.
REQ-002 Parameter: DATA_WIDTH, 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter: DEPTH, 12, implemented words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter: WAIT_STATES, 2, extra cycles inserted before the response; SHALL be >= 0.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 cyc_i  in  1  Wishbone cycle valid.
REQ-008 stb_i  in  1  Wishbone strobe.
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 adr_i  in  ADDR_WIDTH  word address.
REQ-011 sel_i  in  DATA_WIDTH/8  byte lane selects.
REQ-012 dat_i  in  DATA_WIDTH  write data.
REQ-013 dat_o  out  DATA_WIDTH  read data, registered.
REQ-014 ack_o  out  1  normal termination, registered.
REQ-015 err_o  out  1  error termination, registered.

Function
REQ-016 Classic (non-pipelined) Wishbone B4 slave; one transfer in flight; FSM states IDLE, WAIT, RESPOND.
REQ-017 IDLE: on an edge with cyc_i&stb_i high, latch adr_i, we_i, sel_i, dat_i; go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0, else directly to RESPOND.
REQ-018 WAIT: decrement counter each edge; at counter 0 go to RESPOND.
REQ-019 Entry to RESPOND (edge N+1+WAIT_STATES, N = request-sampling edge): ack_o (or err_o) SHALL rise for exactly one cycle; next edge returns to IDLE with ack_o/err_o low.
REQ-020 Write commits at the edge ack_o rises; only lanes with sel_i bit set are updated; other bytes retained.
REQ-021 Read: dat_o loaded with the addressed word at the edge ack_o rises; held until the next read response; unselected lanes still return stored data.
REQ-022 ack_o and err_o SHALL never be high together.
REQ-023 Abort: cyc_i low on any edge while in WAIT -> return to IDLE, no write, no ack_o/err_o.
REQ-024 A request still asserted in the cycle after RESPOND is treated as a new transfer (back-to-back supported, one idle cycle between responses).
REQ-025 stb_i high with cyc_i low SHALL be ignored.

Reset
REQ-026 rst_n_i low: immediately state = IDLE, ack_o = 0, err_o = 0, dat_o = 0, counter = 0, all DEPTH words = 0.
REQ-027 Reset mid-transfer SHALL discard the transfer with no write and no response; first request is sampled on the first edge after rst_n_i deasserts.

Configuration
REQ-028 Macro WB_REGFILE_SLAVE_ERR_EN defined: adr_i >= DEPTH terminates with err_o (same latency as ack_o), no write, dat_o unchanged.
REQ-029 Macro undefined: err_o tied 0; adr_i >= DEPTH terminates with ack_o, writes discarded, reads return 0.

Structure
REQ-030 Package wb_regfile_slave_pkg SHALL hold the FSM state typedef (IDLE, WAIT, RESPOND).
REQ-031 Sub-module wb_regfile_slave_mem SHALL hold the DEPTH x DATA_WIDTH storage with byte-enable write port, async-reset clear, and read port.

Verification (defaults: DEPTH=12, WAIT_STATES=2)
REQ-032 Write adr=3, dat=0xDEADBEEF, sel=4'hF; read adr=3 -> ack_o high exactly at edge N+3 for each, read dat_o=0xDEADBEEF.
REQ-033 Write adr=5 0x11223344 sel=F, then 0xAABBCCDD sel=4'b0101; read adr=5 -> 0x11BB33DD.
REQ-034 Read adr=13 with ERR_EN -> err_o one cycle at N+3, ack_o 0; without ERR_EN -> ack_o, dat_o=0; write to adr=13 then read adr=0..11 -> all unchanged.
REQ-035 Write adr=2, drop cyc_i one cycle after request -> no ack_o/err_o; read adr=2 -> 0.
REQ-036 Write adr=7 0x55; pull rst_n_i low during WAIT of a second write -> ack_o/err_o/dat_o 0 immediately; read adr=7 -> 0.
REQ-037 WAIT_STATES=0, stb_i held high over four back-to-back reads -> ack_o at N+1, N+3, N+5, N+7.
